// File: rtl/soc_pipe_pkg.sv
// Shared constants and helpers for the SoC elastic pipeline register.
package soc_pipe_pkg;

  localparam int PIPE_MIN_DEPTH = 1;

  // Occupancy width: covers 0..2*depth, enough for the two-entry stage variant.
  function automatic int pipe_cnt_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One handshaked pipeline stage; PIPE_REGISTER_SKID_EN selects the two-entry
// skid variant whose upstream ready is a registered "skid empty" flag.
module pipe_stage
  import soc_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clrh,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef logic [DATA_WIDTH-1:0] pipe_data_t;

`ifdef PIPE_REGISTER_SKID_EN
  pipe_data_t main_data, skid_data;
  logic       main_vld, skid_vld;
  logic       in_fire, main_free;

  assign in_fire   = in_valid & ~skid_vld;
  assign main_free = ~main_vld | out_ready;

  // Main entry always leaves first; the skid entry refills main before new input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_vld  <= 1'b0;
      skid_vld  <= 1'b0;
      main_data <= '0;
      skid_data <= '0;
    end else if (clrh) begin
      main_vld  <= 1'b0;
      skid_vld  <= 1'b0;
      main_data <= '0;
      skid_data <= '0;
    end else if (main_free) begin
      if (skid_vld) begin
        main_data <= skid_data;
        main_vld  <= 1'b1;
        skid_vld  <= 1'b0;
      end else if (in_fire) begin
        main_data <= in_data;
        main_vld  <= 1'b1;
      end else begin
        main_vld  <= 1'b0;
      end
    end else if (in_fire) begin
      skid_data <= in_data;
      skid_vld  <= 1'b1;
    end
  end

  assign in_ready  = ~skid_vld;
  assign out_valid = main_vld;
  assign out_data  = main_data;
`else
  pipe_data_t data_q;
  logic       vld_q;

  assign in_ready = ~vld_q | out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (clrh) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (in_ready) begin
      vld_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
`endif

endmodule

// File: rtl/pipe_register.sv
// Elastic pipeline register: DEPTH chained pipe_stage instances plus occupancy
// count. Define PIPE_REGISTER_SKID_EN for registered-ready two-entry stages.
module pipe_register
  import soc_pipe_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 2,
  localparam int CW         = pipe_cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clrh,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         count
);

  typedef logic [DATA_WIDTH-1:0] pipe_data_t;

  if (DEPTH < PIPE_MIN_DEPTH || DATA_WIDTH < 1) begin : g_bad_params
    $error("pipe_register: DEPTH and DATA_WIDTH must both be at least 1");
  end

  logic [DEPTH:0] vld;
  logic [DEPTH:0] rdy;
  pipe_data_t     dat [DEPTH+1];
  logic           in_fire, out_fire;

  // Flush masks both handshake ends so no transfer can coincide with it.
  assign vld[0]     = in_valid & ~clrh;
  assign dat[0]     = in_data;
  assign rdy[DEPTH] = out_ready & ~clrh;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .clk      (clk),
      .rstn     (rstn),
      .clrh     (clrh),
      .in_valid (vld[i]),
      .in_ready (rdy[i]),
      .in_data  (dat[i]),
      .out_valid(vld[i+1]),
      .out_ready(rdy[i+1]),
      .out_data (dat[i+1])
    );
  end

  assign in_ready  = rdy[0] & ~clrh;
  assign out_valid = vld[DEPTH] & ~clrh;
  assign out_data  = dat[DEPTH];

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clrh) begin
      count <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_register.sv
// Bench for pipe_register: directed steps plus random traffic against a FIFO
// reference model; honours PIPE_REGISTER_SKID_EN for capacity expectations.
module tb_pipe_register;
  import soc_pipe_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 3;
  localparam int CW    = pipe_cnt_width(DEPTH);
`ifdef PIPE_REGISTER_SKID_EN
  localparam int CAP = 2 * DEPTH;
`else
  localparam int CAP = DEPTH;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          clrh = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  pipe_register #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .clrh     (clrh),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO of accepted words with the edge index of acceptance.
  logic [DW-1:0] q_data[$];
  int            q_edge[$];
  int            cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q_data.delete();
    q_edge.delete();
  endtask

  // One clock: drive, check against model, predict the coming edge.
  task automatic cycle(input logic iv, input logic [DW-1:0] id,
                       input logic ordy, input logic cl);
    logic exp_ov;
    logic fin, fout;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    clrh      = cl;
    #1;
    exp_ov = !cl && (q_data.size() > 0) && (cyc - q_edge[0] >= DEPTH);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) chk("out_data", 32'(out_data), 32'(q_data[0]));
    chk("count", 32'(count), 32'(q_data.size()));
    if (cl) chk("in_ready_flush", 32'(in_ready), 32'd0);
    else if (q_data.size() == 0) chk("in_ready_empty", 32'(in_ready), 32'd1);
    fin  = in_valid & in_ready;
    fout = out_valid & out_ready;
    if (cl) begin
      model_clear();
    end else begin
      if (fout && q_data.size() > 0) begin
        void'(q_data.pop_front());
        void'(q_edge.pop_front());
      end
      if (fin) begin
        q_data.push_back(in_data);
        q_edge.push_back(cyc);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    // Reset and idle
    #2 rstn = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    #1 chk("idle_out_data", 32'(out_data), 32'd0);

    // Full-rate stream 0x01..0x08
    for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0);
    repeat (DEPTH + 2) cycle(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: fill until in_ready drops, then drain in order
    for (int k = 0; k < 2 * CAP + DEPTH; k++) cycle(1'b1, DW'(8'h10 + k), 1'b0, 1'b0);
    chk("bp_accepts", 32'(q_data.size()), 32'(CAP));
    #1;
    chk("bp_count", 32'(count), 32'(CAP));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    repeat (2 * CAP + DEPTH + 2) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp_drained", 32'(q_data.size()), 32'd0);

    // Simultaneous input and output transfer with one entry held
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    repeat (DEPTH) cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 8'h66, 1'b1, 1'b0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1 chk("simul_count", 32'(count), 32'd1);
    repeat (DEPTH + 2) cycle(1'b0, '0, 1'b1, 1'b0);

    // Flush with two entries and a word waiting on in_data
    cycle(1'b1, 8'h31, 1'b0, 1'b0);
    cycle(1'b1, 8'h32, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    clrh = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    repeat (DEPTH + 2) cycle(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream, then a fresh stream
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h40 + i), 1'b1, 1'b0);
    in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'(8'hA0 + i), 1'b1, 1'b0);
    repeat (DEPTH + 2) cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 39) == 0);
    repeat (2 * CAP + DEPTH + 2) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("final_empty", 32'(q_data.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
